// File: rtl/idli_pkg.sv
// Shared idli definitions: decoder nibble type and SQI read-sequence constants.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  localparam logic [7:0]  SQI_CMD_READ      = 8'h03;
  localparam int unsigned SQI_ADDR_NIBBLES  = 6;
  localparam int unsigned SQI_DUMMY_NIBBLES = 2;

  // Nibble idx (0 = most significant) of the 24b byte address for a 16b word address.
  function automatic sqi_data_t sqi_addr_nibble(input logic [15:0] addr, input logic [2:0] idx);
    logic [23:0] w_byte;
    sqi_data_t   w_nib;
    w_byte = {7'b0, addr, 1'b0};
    case (idx)
      3'd0:    w_nib = w_byte[23:20];
      3'd1:    w_nib = w_byte[19:16];
      3'd2:    w_nib = w_byte[15:12];
      3'd3:    w_nib = w_byte[11:8];
      3'd4:    w_nib = w_byte[7:4];
      3'd5:    w_nib = w_byte[3:0];
      default: w_nib = 4'h0;
    endcase
    return w_nib;
  endfunction

endpackage

// File: rtl/idli_sqi_fetch_m.sv
// SQI instruction fetch: issues a sequential quad read at a redirect address and
// streams the returned nibbles to the decoder, one per unstalled cycle.
module idli_sqi_fetch_m
  import idli_pkg::*;
(
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_redirect,
  input  logic [15:0] i_sqi_addr,
  input  logic        i_sqi_stall,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic        o_sqi_sio_oe,
  output logic [3:0]  o_sqi_sio,
  input  logic [3:0]  i_sqi_sio,
  output sqi_data_t   o_sqi_data,
  output logic        o_sqi_data_vld
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESEL,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA
  } state_t;

  localparam logic [2:0] CMD_LAST   = 3'd1;
  localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
  localparam logic [2:0] DUMMY_LAST = 3'(SQI_DUMMY_NIBBLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [15:0] r_addr;

  // The address is re-latched on every redirect, whatever state we are in.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (i_sqi_redirect) begin
        r_addr <= i_sqi_addr;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_sqi_redirect) begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = 3'd0;
        end
      end
      S_DESEL: begin
        w_state_nxt = S_CMD;
        w_cnt_nxt   = 3'd0;
      end
      S_CMD: begin
        if (i_sqi_redirect) begin
          w_state_nxt = S_DESEL;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt == CMD_LAST) begin
          w_state_nxt = S_ADDR;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_ADDR: begin
        if (i_sqi_redirect) begin
          w_state_nxt = S_DESEL;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt == ADDR_LAST) begin
          w_state_nxt = S_DUMMY;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DUMMY: begin
        if (i_sqi_redirect) begin
          w_state_nxt = S_DESEL;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt == DUMMY_LAST) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DATA: begin
        if (i_sqi_redirect) begin
          w_state_nxt = S_DESEL;
          w_cnt_nxt   = 3'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // In DATA the serial clock is withheld on stall or redirect so the memory holds its nibble.
  always_comb begin
    o_sqi_cs_n     = 1'b1;
    o_sqi_sck_en   = 1'b0;
    o_sqi_sio_oe   = 1'b0;
    o_sqi_sio      = 4'h0;
    o_sqi_data_vld = 1'b0;
    case (r_state)
      S_CMD: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_sio_oe = 1'b1;
        o_sqi_sio    = (r_cnt == 3'd0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
      end
      S_ADDR: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_sio_oe = 1'b1;
        o_sqi_sio    = sqi_addr_nibble(r_addr, r_cnt);
      end
      S_DUMMY: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
      end
      S_DATA: begin
        o_sqi_cs_n     = 1'b0;
        o_sqi_sck_en   = !i_sqi_stall && !i_sqi_redirect;
        o_sqi_data_vld = !i_sqi_stall && !i_sqi_redirect;
      end
      default: begin
        o_sqi_cs_n = 1'b1;
      end
    endcase
  end

  assign o_sqi_data = i_sqi_sio;

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// Self-checking bench for idli_sqi_fetch_m: directed scenarios plus random traffic
// against a transaction-level reference model and a pad-level SQI memory model.
module tb_idli_sqi_fetch_m;
  import idli_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sqi_redirect = 1'b0;
  logic [15:0] i_sqi_addr = 16'h0000;
  logic        i_sqi_stall = 1'b0;
  logic        o_sqi_cs_n;
  logic        o_sqi_sck_en;
  logic        o_sqi_sio_oe;
  logic [3:0]  o_sqi_sio;
  logic [3:0]  i_sqi_sio;
  sqi_data_t   o_sqi_data;
  logic        o_sqi_data_vld;

  idli_sqi_fetch_m dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst_n    (rst_n),
    .i_sqi_redirect (i_sqi_redirect),
    .i_sqi_addr     (i_sqi_addr),
    .i_sqi_stall    (i_sqi_stall),
    .o_sqi_cs_n     (o_sqi_cs_n),
    .o_sqi_sck_en   (o_sqi_sck_en),
    .o_sqi_sio_oe   (o_sqi_sio_oe),
    .o_sqi_sio      (o_sqi_sio),
    .i_sqi_sio      (i_sqi_sio),
    .o_sqi_data     (o_sqi_data),
    .o_sqi_data_vld (o_sqi_data_vld)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  // Memory content: byte b holds b[7:0]^A5, high nibble first in the stream.
  function automatic logic [3:0] memNibble(input logic [24:0] n);
    logic [7:0] b;
    b = n[8:1] ^ 8'hA5;
    return n[0] ? b[3:0] : b[7:4];
  endfunction

  // Pad-level memory: 2 command + 6 address + 2 dummy clocks, then sequential data.
  int          memCount;
  logic [23:0] memByteAddr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memCount    <= 0;
      memByteAddr <= 24'h0;
    end else if (o_sqi_cs_n) begin
      memCount <= 0;
    end else if (o_sqi_sck_en) begin
      if (memCount >= 2 && memCount < 8) memByteAddr <= {memByteAddr[19:0], o_sqi_sio};
      memCount <= memCount + 1;
    end
  end
  always_comb begin
    i_sqi_sio = 4'h0;
    if (!o_sqi_cs_n && memCount >= 10)
      i_sqi_sio = memNibble(25'({memByteAddr, 1'b0}) + 25'(memCount - 10));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: position within the transaction (-1 deselect, 0..9 setup, >=10 data).
  bit          mActive = 0;
  int          mPos = 0;
  logic [15:0] mAddr = 16'h0;
  int          mK = 0;

  int          sinceRedir = 0;
  int          firstVldAt = -1;
  logic [3:0]  firstData = 4'h0;
  int          csHigh = 0;
  int          vldSeen = 0;
  logic [3:0]  sioQ[$];

  function automatic logic [3:0] refSio(input logic [15:0] a, input int p);
    logic [31:0] w;
    w = 32'h0300_0000 | (32'(a) * 32'd2);
    return 4'((w >> (28 - 4 * p)) & 32'hF);
  endfunction

  task automatic applyStimulus(input logic redir, input logic [15:0] addr, input logic stall);
    logic expCs, expOe, expSck, expVld;
    i_sqi_redirect = redir;
    i_sqi_addr     = addr;
    i_sqi_stall    = stall;
    if (redir) begin
      sinceRedir = 0;
      firstVldAt = -1;
      firstData  = 4'h0;
      csHigh     = 0;
      sioQ.delete();
    end
    @(negedge clk);
    expCs  = !(mActive && mPos >= 0);
    expOe  = mActive && mPos >= 0 && mPos < 8;
    expVld = mActive && mPos >= 10 && !stall && !redir;
    expSck = (mActive && mPos >= 0 && mPos < 10) || expVld;
    checkOutput("cs_n", 32'(o_sqi_cs_n), 32'(expCs));
    checkOutput("sio_oe", 32'(o_sqi_sio_oe), 32'(expOe));
    checkOutput("sck_en", 32'(o_sqi_sck_en), 32'(expSck));
    checkOutput("data_vld", 32'(o_sqi_data_vld), 32'(expVld));
    if (expOe) checkOutput("sio", 32'(o_sqi_sio), 32'(refSio(mAddr, mPos)));
    if (expVld) checkOutput("data", 32'(o_sqi_data), 32'(memNibble(25'({mAddr, 2'b00}) + 25'(mK))));
    if (o_sqi_data_vld === 1'b1) begin
      vldSeen++;
      if (firstVldAt < 0) begin
        firstVldAt = sinceRedir;
        firstData  = o_sqi_data;
      end
    end
    if (o_sqi_sio_oe === 1'b1) sioQ.push_back(o_sqi_sio);
    if (sinceRedir > 0 && o_sqi_cs_n === 1'b1) csHigh++;
    @(posedge clk);
    #1;
    sinceRedir++;
    if (redir) begin
      mPos    = (!mActive || mPos == -1) ? 0 : -1;
      mActive = 1;
      mAddr   = addr;
      mK      = 0;
    end else if (mActive) begin
      if (mPos < 10) mPos++;
      else if (!stall) mK++;
    end
  endtask

  logic [3:0] expIdleSio[8];
  logic [3:0] expAbcdSio[8];

  initial begin
    expIdleSio = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    expAbcdSio = '{4'h0, 4'h3, 4'h0, 4'h1, 4'h5, 4'h7, 4'h9, 4'hA};

    #1;
    checkOutput("rst_cs_n", 32'(o_sqi_cs_n), 32'd1);
    checkOutput("rst_sck_en", 32'(o_sqi_sck_en), 32'd0);
    checkOutput("rst_sio_oe", 32'(o_sqi_sio_oe), 32'd0);
    checkOutput("rst_sio", 32'(o_sqi_sio), 32'd0);
    checkOutput("rst_data_vld", 32'(o_sqi_data_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] redirect 0x0000 from IDLE");
    applyStimulus(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("idle_latency", 32'(firstVldAt), 32'd11);
    checkOutput("idle_first_data", 32'(firstData), 32'hA);
    checkOutput("idle_sio_count", 32'(sioQ.size()), 32'd8);
    for (int i = 0; i < 8 && i < sioQ.size(); i++)
      checkOutput($sformatf("idle_sio%0d", i), 32'(sioQ[i]), 32'(expIdleSio[i]));

    $display("[TB] stall for 3 cycles in DATA");
    vldSeen = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("stall_vld_count", 32'(vldSeen), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);

    $display("[TB] redirect 0xABCD from DATA");
    applyStimulus(1'b1, 16'hABCD, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("abcd_latency", 32'(firstVldAt), 32'd12);
    checkOutput("abcd_sio_count", 32'(sioQ.size()), 32'd8);
    for (int i = 0; i < 8 && i < sioQ.size(); i++)
      checkOutput($sformatf("abcd_sio%0d", i), 32'(sioQ[i]), 32'(expAbcdSio[i]));

    $display("[TB] redirect 0x0010 from DATA");
    applyStimulus(1'b1, 16'h0010, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("r10_latency", 32'(firstVldAt), 32'd12);
    checkOutput("r10_cs_high", 32'(csHigh), 32'd1);
    checkOutput("r10_first_data", 32'(firstData), 32'h8);

    $display("[TB] redirect+stall in DATA, second redirect in DESEL");
    applyStimulus(1'b1, 16'h1111, 1'b1);
    applyStimulus(1'b1, 16'h2222, 1'b1);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("dbl_latency", 32'(firstVldAt), 32'd11);
    checkOutput("dbl_first_data", 32'(firstData), 32'hE);

    $display("[TB] reset during ADDR");
    applyStimulus(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_cs_n", 32'(o_sqi_cs_n), 32'd1);
    checkOutput("arst_sck_en", 32'(o_sqi_sck_en), 32'd0);
    checkOutput("arst_sio_oe", 32'(o_sqi_sio_oe), 32'd0);
    checkOutput("arst_data_vld", 32'(o_sqi_data_vld), 32'd0);
    mActive = 0;
    mPos    = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000, 1'($urandom_range(0, 1)));

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom_range(0, 39) == 0), 16'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/idli_sqi_fetch_m.md
# idli_sqi_fetch_m

Drives the SQI instruction memory as a sequential-read initiator and streams returned 4b nibbles to the decoder at one per cycle (the `i_dcd_enc`/`i_dcd_enc_vld` stream). The backend starts a new stream with a redirect carrying a 16b word address. Memory serial clock is `i_sqi_gck` gated externally by `o_sqi_sck_en`. Sits between the SQI pads and `idli_decode_m`.

## Interface
Parameters: none.

Ports:
- `i_sqi_gck`  in  1  core clock; single clock domain.
- `i_sqi_rst_n`  in  1  reset; asynchronous, active-low.
- `i_sqi_redirect`  in  1  start new read at `i_sqi_addr`, aborting any read in progress.
- `i_sqi_addr`  in  16  word address, sampled when `i_sqi_redirect` is high.
- `i_sqi_stall`  in  1  consumer cannot accept a nibble this cycle (DATA only).
- `o_sqi_cs_n`  out  1  memory chip select, active-low.
- `o_sqi_sck_en`  out  1  memory clock enable.
- `o_sqi_sio_oe`  out  1  drive SIO[3:0] from `o_sqi_sio`.
- `o_sqi_sio`  out  4  nibble driven to memory.
- `i_sqi_sio`  in  4  nibble from memory pads.
- `o_sqi_data`  out  `sqi_data_t`  nibble to decoder.
- `o_sqi_data_vld`  out  1  `o_sqi_data` valid this cycle.

## Operation
- States: IDLE, DESEL, CMD, ADDR, DUMMY, DATA. A 3b counter `cnt` indexes nibbles within CMD/ADDR/DUMMY.
- Reset: state IDLE, `cnt`=0, latched address 0. Outputs: `cs_n`=1, `sck_en`=0, `sio_oe`=0, `sio`=0, `data_vld`=0.
- IDLE: `cs_n`=1. On redirect, latch the address and go to CMD.
- DESEL: one cycle with `cs_n`=1 and `sck_en`=0, guaranteeing CS-high time between transactions. Then go to CMD.
- CMD (2 cycles): `cs_n`=0, `sck_en`=1, `oe`=1, `sio` = 4'h0 then 4'h3 (`SQI_CMD_READ`=8'h03, high nibble first).
- ADDR (6 cycles): 24b byte address = {7'b0, addr[15:0], 1'b0}, MSB nibble first:
  - 4'h0
  - {3'b0, a[15]}
  - a[14:11]
  - a[10:7]
  - a[6:3]
  - {a[2:0], 1'b0}
- DUMMY (2 cycles): `oe`=0, `sck_en`=1, `sio`=0.
- DATA: `oe`=0, `cs_n`=0.
  - Not stalled: `sck_en`=1, `o_sqi_data`=`i_sqi_sio` (combinational), `data_vld`=1.
  - Stalled: `sck_en`=0 and `data_vld`=0; the memory holds its nibble.
  - Remains in DATA until redirect; no length limit.
- Redirect in CMD/ADDR/DUMMY/DATA: go to DESEL next cycle, latch the new address, drop the current nibble (`data_vld`=0 in the redirect cycle).
- Redirect in DESEL: re-latch the address; still proceed to CMD next cycle.
- Redirect has priority over stall.
- Stall in IDLE/DESEL/CMD/ADDR/DUMMY is ignored.
- Address wrap 0xFFFF→0x0000 is handled by the memory's sequential counter; no action in this block.
- The stream always begins on a 16b instruction boundary. The backend issues redirect only at instruction boundaries, so the decoder never sees a partial instruction.

## Timing
- `cs_n`, `oe` and `sio` depend only on registered state and `cnt`. `sck_en` and `data_vld` additionally depend on `i_sqi_stall` and `i_sqi_redirect` in DATA.
- Redirect-to-first-valid-nibble latency:
  - From IDLE: redirect at cycle 0; CMD cycles 1–2, ADDR 3–8, DUMMY 9–10; first nibble valid at cycle 11.
  - From an active state: DESEL at cycle 1, first nibble valid at cycle 12.
- Each stall cycle adds one cycle. Nibble order across a stall is preserved with no loss or duplication.
- Reset asserted mid-transaction: outputs take reset values immediately (asynchronously) and the in-flight read is abandoned.

## Structure
- Shared package `idli_pkg` gets:
  - `SQI_CMD_READ` (8'h03)
  - `SQI_ADDR_NIBBLES` (6)
  - `SQI_DUMMY_NIBBLES` (2)
- `sqi_data_t` is reused from `idli_pkg`.
- The state enum is local to the module.
- No sub-module; counter and FSM are inline (est. ~150–200 lines).

## Test plan
- Reset then redirect addr 16'h0000 from IDLE:
  - `cs_n` falls at cycle 1.
  - `sio` = 0,3,0,0,0,0,0,0 over cycles 1–8.
  - `oe`=0 at cycles 9–10.
  - Memory model returns 4'hA,4'h5,… and `data_vld` first rises at cycle 11 with data 4'hA.
- Redirect addr 16'hABCD: ADDR nibbles are 0,1,5,7,9,A (byte address 0x01579A).
- Stall in DATA for 3 cycles after the 2nd nibble: `sck_en`=0 and `data_vld`=0 for 3 cycles; the 3rd nibble follows, with no gap in sequence.
- Redirect in DATA to 16'h0010:
  - Next cycle DESEL with `cs_n`=1 for exactly 1 cycle.
  - Then CMD; first nibble 12 cycles after redirect, from byte address 0x000020.
- Redirect and stall asserted together in DATA, plus a second redirect during DESEL: the second address is used and stall is ignored.
- Reset asserted during ADDR: `cs_n`=1, `sck_en`=0, `data_vld`=0 immediately; block stays IDLE until the next redirect.
